// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer.
// Synchronises the raw rx line, detects the start bit, samples every bit at
// mid-bit using a fractional baud accumulator, checks optional even parity
// and one or two stop bits, and reports each frame with a one-cycle pulse.
module uart_rx_deserializer #(
  parameter int unsigned CLK_FREQ_HZ = 10_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_i,
  input  logic [16:0] baudrate_i,
  input  logic        parity_en_i,
  input  logic        stopbit_i,
  output logic        busy_o,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  output logic        err_parity_o,
  output logic        err_frame_o
);

  localparam int          DATA_W  = 8;
  localparam logic [32:0] LP_CLK  = 33'(CLK_FREQ_HZ);
  localparam logic [31:0] LP_HALF = 32'(CLK_FREQ_HZ / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_t;

  // Even parity of a data word: the parity bit that makes the total count of ones even.
  function automatic logic f_even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  // Next accumulator value: wrap by one clock-frequency unit when a tick fires.
  function automatic logic [31:0] f_acc_next(input logic [32:0] sum, input logic tick);
    logic [32:0] w_red;
    w_red = sum - LP_CLK;
    return tick ? w_red[31:0] : sum[31:0];
  endfunction

  logic              r_rx_meta_p0;
  logic              r_rx_s_p1;
  logic              r_rx_prev_p2;
  state_t            r_state;
  logic [31:0]       r_acc;
  logic [16:0]       r_baud_l;
  logic              r_par_l;
  logic              r_stop_l;
  logic              r_par_ok;
  logic [2:0]        r_bit_cnt;
  logic [DATA_W-1:0] r_shift;

  logic              w_start_edge;
  logic              w_start_go;
  logic [32:0]       w_sum;
  logic              w_tick;
  logic              w_finish;
  logic              w_good;

  // Input synchroniser and previous-sample flop; preset to the idle-high line level.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rx_meta_p0 <= 1'b1;
      r_rx_s_p1    <= 1'b1;
      r_rx_prev_p2 <= 1'b1;
    end else begin
      r_rx_meta_p0 <= rx_i;
      r_rx_s_p1    <= r_rx_meta_p0;
      r_rx_prev_p2 <= r_rx_s_p1;
    end
  end

  // A falling edge on the synchronised line opens a frame unless the rate is zero.
  assign w_start_edge = r_rx_prev_p2 & ~r_rx_s_p1;
  assign w_start_go   = (r_state == S_IDLE) && w_start_edge && (baudrate_i != 17'd0);

  // The accumulator advances by the latched rate every busy cycle; crossing the
  // clock frequency marks one bit time, so fractional rates average out exactly.
  assign w_sum  = {1'b0, r_acc} + {16'd0, r_baud_l};
  assign w_tick = (r_state != S_IDLE) && (w_sum >= LP_CLK);

  // The last stop bit sampled high completes the frame; frame errors abort before this.
  assign w_finish = w_tick && r_rx_s_p1 &&
                    (((r_state == S_STOP1) && !r_stop_l) || (r_state == S_STOP2));
  assign w_good   = !(r_par_l && !r_par_ok);

  // Baud accumulator: preset to half a bit at start so ticks land mid-bit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_acc <= 32'd0;
    end else if (w_start_go) begin
      r_acc <= LP_HALF;
    end else if (r_state != S_IDLE) begin
      r_acc <= f_acc_next(w_sum, w_tick);
    end
  end

  // Data shift register, LSB first; only meaningful while in the data state.
  always_ff @(posedge clk_i) begin
    if (w_tick && (r_state == S_DATA)) begin
      r_shift <= {r_rx_s_p1, r_shift[DATA_W-1:1]};
    end
  end

  // Frame state machine with registered busy, data and one-cycle status pulses.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= S_IDLE;
      r_baud_l     <= 17'd0;
      r_par_l      <= 1'b0;
      r_stop_l     <= 1'b0;
      r_par_ok     <= 1'b0;
      r_bit_cnt    <= 3'd0;
      busy_o       <= 1'b0;
      rx_data_o    <= '0;
      rx_valid_o   <= 1'b0;
      err_parity_o <= 1'b0;
      err_frame_o  <= 1'b0;
    end else begin
      rx_valid_o   <= 1'b0;
      err_parity_o <= 1'b0;
      err_frame_o  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_start_go) begin
            r_baud_l <= baudrate_i;
            r_par_l  <= parity_en_i;
            r_stop_l <= stopbit_i;
            r_state  <= S_START;
            busy_o   <= 1'b1;
          end
        end

        S_START: begin
          if (w_tick) begin
            if (r_rx_s_p1) begin
              // Line back high at mid start bit: glitch, not a frame.
              r_state <= S_IDLE;
              busy_o  <= 1'b0;
            end else begin
              r_state   <= S_DATA;
              r_bit_cnt <= 3'd0;
            end
          end
        end

        S_DATA: begin
          if (w_tick) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= r_par_l ? S_PARITY : S_STOP1;
            end
          end
        end

        S_PARITY: begin
          if (w_tick) begin
            r_par_ok <= (r_rx_s_p1 == f_even_par(r_shift));
            r_state  <= S_STOP1;
          end
        end

        S_STOP1: begin
          if (w_tick) begin
            if (!r_rx_s_p1) begin
              err_frame_o <= 1'b1;
              r_state     <= S_IDLE;
              busy_o      <= 1'b0;
            end else if (r_stop_l) begin
              r_state <= S_STOP2;
            end
          end
        end

        S_STOP2: begin
          if (w_tick && !r_rx_s_p1) begin
            err_frame_o <= 1'b1;
            r_state     <= S_IDLE;
            busy_o      <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          busy_o  <= 1'b0;
        end
      endcase

      // Completion at the mid-point of the last stop bit, so the next start edge is caught.
      if (w_finish) begin
        if (w_good) begin
          rx_data_o  <= r_shift;
          rx_valid_o <= 1'b1;
        end else begin
          err_parity_o <= 1'b1;
        end
        r_state <= S_IDLE;
        busy_o  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- Serial-to-parallel UART receive core that sits directly upstream of the UART RX system-bus controller.
- Synchronises the raw rx line and detects the start bit.
- Samples each bit at mid-bit using a fractional baud accumulator, then checks optional parity and 1 or 2 stop bits.
- Delivers each good byte with a one-cycle valid pulse; the controller exposes these as registers and as an interrupt.

Parameters:
- CLK_FREQ_HZ, 10_000_000, system clock frequency in Hz; the reference value for the baud accumulator.

Ports:
- clk_i  in  1  system clock, rising-edge.
- rst_i  in  1  asynchronous, active-low reset.
- rx_i  in  1  raw serial line, asynchronous to clk_i, idle high.
- baudrate_i  in  17  baud rate in bit/s; latched at start detection.
- parity_en_i  in  1  1 = one even-parity bit follows the data; latched at start detection.
- stopbit_i  in  1  0 = one stop bit, 1 = two stop bits; latched at start detection.
- busy_o  out  1  frame in progress.
- rx_data_o  out  8  last correctly received byte.
- rx_valid_o  out  1  one-cycle pulse, rx_data_o newly updated.
- err_parity_o  out  1  one-cycle pulse, parity mismatch; byte discarded.
- err_frame_o  out  1  one-cycle pulse, stop bit sampled low; byte discarded.

Behaviour:
- Reset (rst_i low, asynchronous):
  - all outputs 0, state IDLE, accumulator 0;
  - synchroniser flops and the previous-sample flop preset to 1 (line idle).
- Input path:
  - rx_s = rx_i passed through a 2-flop synchroniser;
  - rx_prev = rx_s delayed one cycle;
  - start edge = rx_prev==1 && rx_s==0.
- Baud tick:
  - 32-bit accumulator acc; each cycle while not IDLE, sum = acc + baud_l;
  - if sum >= CLK_FREQ_HZ: tick=1, acc <= sum - CLK_FREQ_HZ;
  - else: acc <= sum.
  - No divider. Fractional rates average correctly, e.g. 9600 baud at 10 MHz = 1041.67 clk/bit.
- Start detect, in IDLE:
  - on start edge with baudrate_i != 0: latch baud_l, par_l, stop_l; acc <= CLK_FREQ_HZ/2; go to START; busy_o <= 1.
  - the acc preset makes the first tick land near the middle of the start bit.
  - start edge with baudrate_i == 0: ignored, stay IDLE.
- FSM (all state actions occur only on a tick cycle):
  - START:
    - rx_s==1 -> false start: IDLE, busy_o<=0, no pulses.
    - otherwise -> DATA, bit_cnt<=0.
  - DATA:
    - shift rx_s into the shift register, LSB first; bit_cnt++.
    - after the 8th bit -> PARITY if par_l, else STOP1.
  - PARITY: store par_ok = (rx_s == ^shift_reg); -> STOP1.
  - STOP1:
    - rx_s==0 -> err_frame_o pulse, IDLE.
    - else if stop_l -> STOP2.
    - else -> finish.
  - STOP2: rx_s==0 -> err_frame_o pulse, IDLE; else -> finish.
  - finish, same cycle as the final stop-bit tick:
    - par_l && !par_ok -> err_parity_o pulse, rx_data_o unchanged.
    - otherwise -> rx_data_o <= shift_reg, rx_valid_o pulse.
    - then IDLE, busy_o<=0.
- Frame error takes priority over parity error; exactly one pulse per frame at most.
- Return to IDLE at the mid-point of the last stop bit, so a start edge in the next bit time is caught (back-to-back frames).
- Line held low after a frame error (break): no new start until rx_s returns high and then falls.
- busy_o is high from the cycle after start detect through the finish or abort cycle. It is registered, so it falls the cycle after the last tick.
- baudrate_i, parity_en_i and stopbit_i changes while busy_o=1 have no effect on the current frame.
- Reset asserted mid-frame: immediate abort; no pulse is emitted during or after reset.
- rx_data_o holds its value until the next good frame. Pulse outputs are never high for more than one cycle.

Test Plan:
- CLK_FREQ_HZ=10_000_000, baudrate_i=1_000_000 (10 clk/bit), no parity, 1 stop, send 0x55 -> exactly one rx_valid_o pulse; rx_data_o=0x55; busy_o high ~95 clk; no error pulses.
- parity_en_i=1:
  - send 0xA3 with parity bit 0 -> valid pulse, rx_data_o=0xA3;
  - then send 0x3C with parity bit 1 -> err_parity_o pulse, no valid, rx_data_o stays 0xA3.
- Stop bit driven low, then line held low 30 bit times -> single err_frame_o pulse, no valid, busy_o low; release high, send 0x0F -> valid, rx_data_o=0x0F.
- rx_i low for 3 clk only -> busy_o rises then falls at the START tick; no valid or error pulses; rx_data_o unchanged.
- stopbit_i=1, baudrate_i=9600, two back-to-back frames 0x01, 0xFE; baudrate_i changed to 19200 mid-first-frame -> both bytes received, two valid pulses ~11 bit times apart.
- rst_i pulsed low for 1 clk mid-DATA, asynchronous to clk_i edge -> all outputs 0 immediately, no pulse; next frame 0x81 -> rx_data_o=0x81.
